// File: rtl/pipe_pkg.sv
// Shared defaults and stage-index names for the instruction pipeline controller.
// Stage 0 is the youngest (EXE); the highest index is the oldest (WB).
package pipe_pkg;

   localparam int STAGES_DEF    = 3;
   localparam int PAYLOAD_W_DEF = 64;
   localparam int DATA_W_DEF    = 32;
   localparam int RADDR_W_DEF   = 5;

   localparam int EXE = 0;
   localparam int MEM = 1;
   localparam int WB  = 2;

   localparam int NUM_SRC = 2;
   localparam int FLUSH_W = 3;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register slice: valid bit plus held payload/we/dest and its allowin term.
// The valid bit is reset; the data registers are not and only load on a real transfer.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int RADDR_W   = RADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 up_valid,
   input  logic [PAYLOAD_W-1:0] up_payload,
   input  logic                 up_we,
   input  logic [RADDR_W-1:0]   up_dest,
   input  logic                 ready_go,
   input  logic                 next_allowin,
   input  logic                 kill,
   output logic                 allowin,
   output logic                 valid,
   output logic [PAYLOAD_W-1:0] payload,
   output logic                 we,
   output logic [RADDR_W-1:0]   dest
);

   logic                 valid_q, valid_d;
   logic                 we_q, we_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;
   logic [RADDR_W-1:0]   dest_q, dest_d;
   logic                 load;

   always_comb begin
      allowin   = ~valid_q | (ready_go & next_allowin);
      load      = allowin & up_valid;
      valid_d   = allowin ? up_valid : valid_q;
      // A kill wins over whatever was about to move in.
      if (kill) begin
         valid_d = 1'b0;
      end
      payload_d = load ? up_payload : payload_q;
      we_d      = load ? up_we      : we_q;
      dest_d    = load ? up_dest    : dest_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      payload_q <= payload_d;
      we_q      <= we_d;
      dest_q    <= dest_d;
   end

   assign valid   = valid_q;
   assign payload = payload_q;
   assign we      = we_q;
   assign dest    = dest_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: STAGES register slices with allowin back-pressure, flush,
// retirement handshake, and youngest-first operand forwarding with load-use stall.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int STAGES    = STAGES_DEF,
   parameter int PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int RADDR_W   = RADDR_W_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_allowin,
   input  logic [PAYLOAD_W-1:0]          in_payload,
   input  logic                          in_we,
   input  logic [RADDR_W-1:0]            in_dest,
   input  logic [STAGES-1:0]             stage_ready_go,
   input  logic [STAGES*DATA_W-1:0]      stage_result,
   input  logic [STAGES-1:0]             stage_result_valid,
   output logic [STAGES-1:0]             stage_valid,
   output logic [STAGES*PAYLOAD_W-1:0]   stage_payload,
   input  logic                          flush_req,
   input  logic [FLUSH_W-1:0]            flush_stage,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_we,
   output logic [RADDR_W-1:0]            out_dest,
   output logic [DATA_W-1:0]             out_data,
   input  logic [RADDR_W-1:0]            src1,
   input  logic [RADDR_W-1:0]            src2,
   output logic [NUM_SRC-1:0]            fwd_hit,
   output logic [NUM_SRC*DATA_W-1:0]     fwd_data,
   output logic                          stall
);

   // Handshake: stage k hands over when valid[k] & ready_go[k] & allowin[k+1];
   // allowin[k] = !valid[k] | (ready_go[k] & allowin[k+1]), allowin[STAGES] = out_ready,
   // so a full, stuck tail stalls everything upstream in the same cycle.
   logic [STAGES:0]      allowin;
   logic [STAGES-1:0]    valid_w;
   logic [STAGES-1:0]    we_w;
   logic [RADDR_W-1:0]   dest_w [STAGES];
   logic [PAYLOAD_W-1:0] pay_w  [STAGES];

   logic [STAGES-1:0]    up_valid;
   logic [STAGES-1:0]    up_we;
   logic [RADDR_W-1:0]   up_dest [STAGES];
   logic [PAYLOAD_W-1:0] up_pay  [STAGES];
   logic [STAGES-1:0]    kill;
   logic [NUM_SRC-1:0]   stall_src;

   assign allowin[STAGES] = out_ready;
   assign in_allowin      = allowin[0];

   // flush_stage values past the tail simply cover every stage.
   always_comb begin
      kill = '0;
      for (int k = 0; k < STAGES; k++) begin
         kill[k] = flush_req && (int'(flush_stage) >= k);
      end
   end

   // A killed instruction must not leak into the next (older) stage either.
   always_comb begin
      up_valid   = '0;
      up_we      = '0;
      up_valid[0] = in_valid & ~stall;
      up_we[0]    = in_we;
      up_dest[0]  = in_dest;
      up_pay[0]   = in_payload;
      for (int k = 1; k < STAGES; k++) begin
         up_valid[k] = valid_w[k-1] & stage_ready_go[k-1] & ~kill[k-1];
         up_we[k]    = we_w[k-1];
         up_dest[k]  = dest_w[k-1];
         up_pay[k]   = pay_w[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_stage #(
         .PAYLOAD_W (PAYLOAD_W),
         .RADDR_W   (RADDR_W)
      ) u_stage (
         .clk          (clk),
         .reset        (reset),
         .up_valid     (up_valid[k]),
         .up_payload   (up_pay[k]),
         .up_we        (up_we[k]),
         .up_dest      (up_dest[k]),
         .ready_go     (stage_ready_go[k]),
         .next_allowin (allowin[k+1]),
         .kill         (kill[k]),
         .allowin      (allowin[k]),
         .valid        (valid_w[k]),
         .payload      (pay_w[k]),
         .we           (we_w[k]),
         .dest         (dest_w[k])
      );
      assign stage_payload[k*PAYLOAD_W +: PAYLOAD_W] = valid_w[k] ? pay_w[k] : '0;
   end

   assign stage_valid = valid_w;

   // Scan oldest to youngest so the youngest matching producer is the one left standing.
   always_comb begin
      logic [RADDR_W-1:0] src;
      logic               hit;
      logic               rv;
      logic [DATA_W-1:0]  data;
      fwd_hit   = '0;
      fwd_data  = '0;
      stall_src = '0;
      src       = '0;
      hit       = 1'b0;
      rv        = 1'b0;
      data      = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         src  = (s == 0) ? src1 : src2;
         hit  = 1'b0;
         rv   = 1'b0;
         data = '0;
         for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid_w[k] && we_w[k] && (dest_w[k] == src) && (src != '0)) begin
               hit  = 1'b1;
               rv   = stage_result_valid[k];
               data = stage_result[k*DATA_W +: DATA_W];
            end
         end
         fwd_hit[s] = hit & rv & ~reset;
         if (fwd_hit[s]) begin
            fwd_data[s*DATA_W +: DATA_W] = data;
         end
         stall_src[s] = hit & ~rv;
      end
   end

   assign stall = (|stall_src) & ~reset;

   assign out_valid = valid_w[STAGES-1] & stage_ready_go[STAGES-1] & ~reset;
   assign out_we    = out_valid & we_w[STAGES-1];
   assign out_dest  = out_valid ? dest_w[STAGES-1] : '0;
   assign out_data  = stage_result[(STAGES-1)*DATA_W +: DATA_W];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: retirement scoreboard, forwarding vector table, and
// hand-written back-pressure, load-use, flush and reset sequences.
module tb_pipe_ctrl;

   localparam int STAGES    = 3;
   localparam int PAYLOAD_W = 64;
   localparam int DATA_W    = 32;
   localparam int RADDR_W   = 5;
   localparam int EXP_W     = PAYLOAD_W + 1 + RADDR_W;

   logic                        clk;
   logic                        reset;
   logic                        in_valid;
   logic                        in_allowin;
   logic [PAYLOAD_W-1:0]        in_payload;
   logic                        in_we;
   logic [RADDR_W-1:0]          in_dest;
   logic [STAGES-1:0]           stage_ready_go;
   logic [STAGES*DATA_W-1:0]    stage_result;
   logic [STAGES-1:0]           stage_result_valid;
   logic [STAGES-1:0]           stage_valid;
   logic [STAGES*PAYLOAD_W-1:0] stage_payload;
   logic                        flush_req;
   logic [2:0]                  flush_stage;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_we;
   logic [RADDR_W-1:0]          out_dest;
   logic [DATA_W-1:0]           out_data;
   logic [RADDR_W-1:0]          src1;
   logic [RADDR_W-1:0]          src2;
   logic [1:0]                  fwd_hit;
   logic [2*DATA_W-1:0]         fwd_data;
   logic                        stall;

   logic [EXP_W-1:0] exp_q[$];
   int               acc_q[$];
   int               total;
   int               bad;
   int               cyc;
   bit               acc_flag;
   bit               chk_lat;

   pipe_ctrl #(
      .STAGES    (STAGES),
      .PAYLOAD_W (PAYLOAD_W),
      .DATA_W    (DATA_W),
      .RADDR_W   (RADDR_W)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .in_valid           (in_valid),
      .in_allowin         (in_allowin),
      .in_payload         (in_payload),
      .in_we              (in_we),
      .in_dest            (in_dest),
      .stage_ready_go     (stage_ready_go),
      .stage_result       (stage_result),
      .stage_result_valid (stage_result_valid),
      .stage_valid        (stage_valid),
      .stage_payload      (stage_payload),
      .flush_req          (flush_req),
      .flush_stage        (flush_stage),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_we             (out_we),
      .out_dest           (out_dest),
      .out_data           (out_data),
      .src1               (src1),
      .src2               (src2),
      .fwd_hit            (fwd_hit),
      .fwd_data           (fwd_data),
      .stall              (stall)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [RADDR_W-1:0] d2, d1, d0;
      logic [2:0]         we, rv;
      logic [RADDR_W-1:0] s1, s2;
      logic [1:0]         hit;
      logic [DATA_W-1:0]  f1, f2;
      logic               st;
   } fvec_t;

   fvec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event want none", name);
   endtask

   // Samples just after the inputs settle, then advances one clock.
   task automatic step();
      logic [EXP_W-1:0] e;
      int               a;
      #1;
      acc_flag = 1'b0;
      if (reset) begin
         exp_q.delete();
         acc_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("retire_unexpected");
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("retire_payload", stage_payload[(STAGES-1)*PAYLOAD_W +: PAYLOAD_W],
                     e[EXP_W-1 -: PAYLOAD_W]);
               check("retire_we_dest", {out_we, out_dest}, e[RADDR_W:0]);
               check("retire_data", out_data, stage_result[(STAGES-1)*DATA_W +: DATA_W]);
               if (chk_lat) check("latency", cyc - a, STAGES);
            end
         end
         if (in_valid && in_allowin && !stall) begin
            exp_q.push_back({in_payload, in_we, in_dest});
            acc_q.push_back(cyc);
            acc_flag = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic send(input logic [PAYLOAD_W-1:0] p, input logic [RADDR_W-1:0] d, input logic w);
      in_valid   = 1'b1;
      in_payload = p;
      in_dest    = d;
      in_we      = w;
      for (int t = 0; t < 20; t++) begin
         step();
         if (acc_flag) break;
      end
      if (!acc_flag) fail_now("send_timeout");
      in_valid = 1'b0;
   endtask

   task automatic reset_pipe();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic drain(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 10; t++) step();
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; chk_lat = 1'b0;
      reset = 1'b1; in_valid = 1'b0; in_payload = '0; in_we = 1'b0; in_dest = '0;
      stage_ready_go = '1; stage_result_valid = '1;
      stage_result = {32'h33, 32'h22, 32'h11};
      flush_req = 1'b0; flush_stage = '0; out_ready = 1'b1; src1 = '0; src2 = '0;

      vecs[0] = '{5'd3, 5'd5, 5'd5, 3'b111, 3'b111, 5'd5, 5'd3, 2'b11, 32'h11, 32'h33, 1'b0};
      vecs[1] = '{5'd0, 5'd0, 5'd0, 3'b111, 3'b111, 5'd0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b0};
      vecs[2] = '{5'd1, 5'd2, 5'd3, 3'b111, 3'b111, 5'd9, 5'd4, 2'b00, 32'h0,  32'h0,  1'b0};
      vecs[3] = '{5'd1, 5'd2, 5'd7, 3'b111, 3'b110, 5'd2, 5'd7, 2'b01, 32'h22, 32'h0,  1'b1};
      vecs[4] = '{5'd4, 5'd4, 5'd6, 3'b111, 3'b101, 5'd4, 5'd6, 2'b10, 32'h0,  32'h11, 1'b1};
      vecs[5] = '{5'd8, 5'd8, 5'd8, 3'b100, 3'b111, 5'd8, 5'd8, 2'b11, 32'h33, 32'h33, 1'b0};
      vecs[6] = '{5'd9, 5'd9, 5'd9, 3'b111, 3'b110, 5'd9, 5'd0, 2'b00, 32'h0,  32'h0,  1'b1};

      // Reset state
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_stall", stall, 0);
      check("rst_fwd_hit", fwd_hit, 0);
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_stage_valid", stage_valid, 0);
      check("rst_allowin", in_allowin, 1);
      check("rst_out_valid_after", out_valid, 0);
      @(negedge clk);

      // Streaming: 10 back-to-back, latency STAGES each
      chk_lat = 1'b1;
      for (int i = 0; i < 10; i++) send(64'hA000 + 64'(i), 5'(i + 1), 1'b1);
      drain("stream_drain");
      chk_lat = 1'b0;

      // Back-pressure with full pipe
      reset_pipe();
      for (int i = 0; i < 3; i++) send(64'hB000 + 64'(i), 5'(i + 11), 1'b1);
      begin
         logic [STAGES*PAYLOAD_W-1:0] snap;
         out_ready  = 1'b0;
         in_valid   = 1'b1;
         in_payload = 64'hB003;
         in_dest    = 5'd14;
         in_we      = 1'b0;
         #1;
         snap = stage_payload;
         check("bp_full", stage_valid, 3'b111);
         for (int t = 0; t < 4; t++) begin
            check("bp_allowin", in_allowin, 0);
            step();
            #1;
            check("bp_frozen", stage_payload == snap, 1);
         end
      end
      out_ready = 1'b1;
      send(64'hB003, 5'd14, 1'b0);
      send(64'hB004, 5'd15, 1'b1);
      drain("bp_drain");

      // Forwarding table
      for (int v = 0; v < 7; v++) begin
         reset_pipe();
         out_ready = 1'b0;
         send(64'hC000 + 64'(v), vecs[v].d2, vecs[v].we[2]);
         send(64'hC100 + 64'(v), vecs[v].d1, vecs[v].we[1]);
         send(64'hC200 + 64'(v), vecs[v].d0, vecs[v].we[0]);
         stage_result_valid = vecs[v].rv;
         src1 = vecs[v].s1;
         src2 = vecs[v].s2;
         #1;
         check("fwd_hit", fwd_hit, vecs[v].hit);
         check("fwd_data1", fwd_data[DATA_W-1:0], vecs[v].f1);
         check("fwd_data2", fwd_data[2*DATA_W-1:DATA_W], vecs[v].f2);
         check("fwd_stall", stall, vecs[v].st);
         stage_result_valid = '1;
         src1 = '0;
         src2 = '0;
         @(negedge clk);
      end

      // Load-use stall, presented instruction must not be lost
      reset_pipe();
      out_ready = 1'b1;
      send(64'hD000, 5'd7, 1'b1);
      stage_result_valid = 3'b110;
      src2       = 5'd7;
      in_valid   = 1'b1;
      in_payload = 64'hD001;
      in_dest    = 5'd1;
      in_we      = 1'b1;
      #1;
      check("lu_stall", stall, 1);
      check("lu_allowin", in_allowin, 1);
      check("lu_hit", fwd_hit[1], 0);
      step();
      stage_result_valid = '1;
      #1;
      check("lu_release", stall, 0);
      check("lu_hit_now", fwd_hit[1], 1);
      step();
      check("lu_accepted", acc_flag, 1);
      src2 = '0;
      drain("lu_drain");

      // Flush stages 0..1 with all full; stage 2 retires
      reset_pipe();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(64'hE000 + 64'(i), 5'(i + 20), 1'b1);
      flush_req   = 1'b1;
      flush_stage = 3'd1;
      step();
      flush_req = 1'b0;
      void'(exp_q.pop_back()); void'(exp_q.pop_back());
      void'(acc_q.pop_back()); void'(acc_q.pop_back());
      #1;
      check("flush_valid", stage_valid, 3'b100);
      drain("flush_drain");

      // Flush past the tail clears everything
      reset_pipe();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(64'hE100 + 64'(i), 5'(i + 24), 1'b1);
      flush_req   = 1'b1;
      flush_stage = 3'd7;
      step();
      flush_req = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      check("flush_all_valid", stage_valid, 3'b000);
      check("flush_all_out", out_valid, 0);
      @(negedge clk);

      // Reset mid-stream
      reset_pipe();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(64'hF000 + 64'(i), 5'(i + 2), 1'b1);
      reset = 1'b1;
      #1;
      check("midrst_during", out_valid, 0);
      step();
      reset = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_stage_valid", stage_valid, 0);
      check("midrst_allowin", in_allowin, 1);
      @(negedge clk);
      drain("midrst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 3, number of post-decode pipeline stages (index 0 = youngest/EXE, STAGES-1 = oldest/WB); legal range 2..8.
REQ-002 Parameter PAYLOAD_W, default 64, width of opaque per-instruction payload.
REQ-003 Parameter DATA_W, default 32, register data width.
REQ-004 Parameter RADDR_W, default 5, register-number width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  decode stage presents an instruction.
REQ-008 in_allowin  output  1  stage 0 accepts an instruction this cycle.
REQ-009 in_payload  input  PAYLOAD_W  instruction payload.
REQ-010 in_we / in_dest  input  1 / RADDR_W  register-write enable and destination.
REQ-011 stage_ready_go  input  STAGES  per-stage "work done" flag (e.g. memory response returned).
REQ-012 stage_result / stage_result_valid  input  STAGES*DATA_W / STAGES  per-stage computed write data and its availability.
REQ-013 stage_valid / stage_payload  output  STAGES / STAGES*PAYLOAD_W  per-stage valid and held payload, flat, stage 0 in LSBs.
REQ-014 flush_req / flush_stage  input  1 / 3  kill stages 0..flush_stage inclusive.
REQ-015 out_valid / out_ready  output / input  1 / 1  retirement handshake from stage STAGES-1.
REQ-016 out_we / out_dest / out_data  output  1 / RADDR_W / DATA_W  retiring register write.
REQ-017 src1, src2  input  RADDR_W each  decode source registers for hazard query.
REQ-018 fwd_hit, fwd_data  output  2 / 2*DATA_W  per-source forward valid and value (src1 in LSBs).
REQ-019 stall  output  1  decode shall hold: an operand depends on a result not yet available.

Function
REQ-020 allowin[k] SHALL be !valid[k] | (stage_ready_go[k] & allowin[k+1]); allowin[STAGES] is out_ready; in_allowin = allowin[0].
REQ-021 Stage k SHALL load valid/payload/we/dest when allowin[k]; valid[k] <= valid[k-1] & ready_go[k-1] (valid[-1] = in_valid & !stall); payload registers update only on an actual transfer.
REQ-022 Latency: an instruction with all ready_go high and out_ready high SHALL reach out_valid exactly STAGES cycles after acceptance; throughput one per cycle.
REQ-023 out_valid SHALL equal valid[STAGES-1] & stage_ready_go[STAGES-1]; out_we = out_valid & we[STAGES-1]; out_data = stage_result slice STAGES-1.
REQ-024 Forward match for source s at stage k: valid[k] & we[k] & dest[k]==s & s!=0.
REQ-025 Youngest matching stage (lowest k) SHALL win; fwd_hit set and fwd_data = its stage_result when its stage_result_valid is 1.
REQ-026 stall SHALL assert when the winning match has stage_result_valid=0 (load-use); fwd_hit for that source is then 0.
REQ-027 Register 0 SHALL never match; no match yields fwd_hit=0, fwd_data=0.
REQ-028 flush_req SHALL clear valid[0..flush_stage] at the next edge, overriding any simultaneous transfer into those stages; older stages advance normally; flush_stage >= STAGES flushes all.
REQ-029 A stage holding (allowin low) SHALL keep payload, we, dest unchanged.
REQ-030 When out_ready is low and stage STAGES-1 is full, back-pressure SHALL propagate combinationally so that no instruction is lost or duplicated.

Reset
REQ-031 Reset SHALL clear all valid bits; out_valid, out_we, fwd_hit, stall = 0 during and the cycle after reset.
REQ-032 Payload, we, dest registers need no reset; outputs derived from them SHALL be masked by valid.
REQ-033 Reset mid-operation SHALL discard all in-flight instructions; in_allowin = 1 first cycle after reset deasserts.

Structure
REQ-034 Default parameters and the stage-index constants (EXE=0, MEM=1, WB=2) SHALL live in shared package pipe_pkg.
REQ-035 One sub-module pipe_stage (valid/payload register slice with allowin logic) SHALL be instantiated STAGES times via generate.
REQ-036 Hazard/forward selection SHALL be a priority loop in pipe_ctrl, no extra module.

Verification
REQ-037 Streaming: 10 back-to-back instructions, all ready high -> out_valid 10 consecutive cycles starting cycle 3, dests in order.
REQ-038 Back-pressure: out_ready low 4 cycles with pipe full -> in_allowin low, stage payloads frozen, none lost on release.
REQ-039 Forward: stage 0 writes r5=0x11, stage 1 writes r5=0x22, src1=5 -> fwd_hit[0]=1, fwd_data=0x11.
REQ-040 Load-use: stage 0 writes r7 with result_valid=0, src2=7 -> stall=1, in_allowin unaffected, no bubble lost; result_valid=1 next cycle -> stall=0.
REQ-041 Flush: flush_stage=1 with all stages full -> valid[0],valid[1] 0 next cycle, stage 2 retires.
REQ-042 r0 and reset: dest=0 src1=0 -> fwd_hit=0; reset asserted mid-stream -> out_valid 0 next cycle.
